// File: rtl/deserializador_sincrono_pkg.sv
// ============================================================================
// Module      : deserializador_sincrono_pkg
// Description : Shared types and constants for the synchronous 4-bit
//               serial-to-parallel receiver and its bit index counter.
//               - estado_t      : receiver FSM encoding (IDLE / RECIBIENDO)
//               - WORD_W        : parallel word width (4)
//               - FRAME_LEN     : bits per frame (4, or 5 with parity)
//               - IDX_W         : width of the internal bit index
//               - paridad_error : even-parity check helper
// Config      : DESERIALIZADOR_PARIDAD_EN selects the 5-bit frame with a
//               trailing even-parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package deserializador_sincrono_pkg;

  // FSM encoding: IDLE holds no partial bits, RECIBIENDO holds 1..N-1 bits.
  typedef enum logic {
    IDLE       = 1'b0,
    RECIBIENDO = 1'b1
  } estado_t;

  localparam int WORD_W            = 4;
  localparam int FRAME_LEN_DATOS   = 4;
  localparam int FRAME_LEN_PARIDAD = 5;

`ifdef DESERIALIZADOR_PARIDAD_EN
  localparam int FRAME_LEN = FRAME_LEN_PARIDAD;
  localparam int IDX_W     = 3;
`else
  localparam int FRAME_LEN = FRAME_LEN_DATOS;
  localparam int IDX_W     = 2;
`endif

  // 1 when data plus its parity bit do not form an even number of ones.
  function automatic logic paridad_error(input logic [WORD_W-1:0] data,
                                         input logic              par);
    return (^data) ^ par;
  endfunction

endpackage

`default_nettype wire

// File: rtl/deserializador_sincrono_contador_indice.sv
// ============================================================================
// Module      : contador_indice
// Description : Bit index counter for the serial receiver. Counts accepted
//               bits modulo the frame length and flags the frame's last bit.
// Ports       : clk   in  clock, rising edge
//               rst   in  synchronous active-high reset
//               clear in  frame restart (drop partial count)
//               inc   in  a bit is accepted this cycle
//               index out index of the next bit expected (registered)
//               done  out the bit accepted this cycle completes the frame
// Config      : frame length follows DESERIALIZADOR_PARIDAD_EN via the package.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module contador_indice
  import deserializador_sincrono_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [IDX_W-1:0] index,
  output logic             done
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

  // A restart makes the accepted bit bit 0, so it can never close a frame.
  assign done = inc & ~clear & (index == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      index <= '0;
    end else if (clear) begin
      index <= inc ? ONE : '0;
    end else if (inc) begin
      index <= (index == LAST) ? '0 : index + ONE;
    end
  end

endmodule

`default_nettype wire

// File: rtl/deserializador_sincrono.sv
// ============================================================================
// Module      : deserializador_sincrono
// Description : Synchronous 4-bit serial-to-parallel receiver. Accepts one
//               LSB-first bit per qualified edge, assembles 4-bit words and
//               hands them downstream through a valid/ready holding register.
// Ports       : iClock       in   clock, rising edge
//               iReset       in   synchronous active-high reset
//               iSerial      in   serial data bit
//               iValid       in   iSerial valid this cycle
//               iStart       in   frame start; this cycle's bit is bit 0
//               iReady       in   consumer accepts oData while oValid=1
//               oData        out  assembled word, held while oValid=1
//               oValid       out  oData holds an undelivered word
//               oIndex       out  index of the next bit expected
//               oBusy        out  partial word in progress
//               oOverflow    out  sticky: a completed word was dropped
//               oParityError out  parity mismatch for current oData
// Config      : DESERIALIZADOR_PARIDAD_EN adds a 5th even-parity bit per
//               frame; otherwise oParityError is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module deserializador_sincrono
  import deserializador_sincrono_pkg::*;
(
  input  logic              iClock,
  input  logic              iReset,
  input  logic              iSerial,
  input  logic              iValid,
  input  logic              iStart,
  input  logic              iReady,
  output logic [WORD_W-1:0] oData,
  output logic              oValid,
  output logic [1:0]        oIndex,
  output logic              oBusy,
  output logic              oOverflow,
  output logic              oParityError
);

  estado_t           estado;
  logic [IDX_W-1:0]  index;
  logic              done;
  logic [IDX_W-1:0]  pos;
  logic [WORD_W-1:0] shift_q;
  logic [WORD_W-1:0] shift_next;

  contador_indice u_contador_indice (
    .clk   (iClock),
    .rst   (iReset),
    .clear (iStart),
    .inc   (iValid),
    .index (index),
    .done  (done)
  );

  // Partial word after this edge. On a restart the old bits are dropped and
  // the incoming bit lands at position 0. When the frame completes this is
  // also the full word to hand downstream (bit 3 merged in the same cycle).
  always_comb begin
    pos        = iStart ? '0 : index;
    shift_next = iStart ? '0 : shift_q;
`ifdef DESERIALIZADOR_PARIDAD_EN
    // The last position is the parity bit; it is not part of the word.
    if (iValid && (pos != IDX_W'(FRAME_LEN - 1))) begin
      shift_next[pos[1:0]] = iSerial;
    end
`else
    if (iValid) begin
      shift_next[pos] = iSerial;
    end
`endif
  end

`ifdef DESERIALIZADOR_PARIDAD_EN
  // With a 5-bit frame index 4 aliases to 0 on the 2-bit port; oBusy still
  // distinguishes a parity bit pending from an idle receiver.
  assign oIndex = index[1:0];
`else
  assign oIndex = index;
`endif

  assign oBusy = (estado == RECIBIENDO);

`ifndef DESERIALIZADOR_PARIDAD_EN
  assign oParityError = 1'b0;
`endif

  always_ff @(posedge iClock) begin
    if (iReset) begin
      estado    <= IDLE;
      shift_q   <= '0;
      oData     <= '0;
      oValid    <= 1'b0;
      oOverflow <= 1'b0;
`ifdef DESERIALIZADOR_PARIDAD_EN
      oParityError <= 1'b0;
`endif
    end else begin
      case (estado)
        IDLE: begin
          if (iValid) estado <= RECIBIENDO;
        end
        RECIBIENDO: begin
          if (iStart)    estado <= iValid ? RECIBIENDO : IDLE;
          else if (done) estado <= IDLE;
        end
        default: estado <= IDLE;
      endcase

      shift_q <= done ? '0 : shift_next;

      // Holding register: a completing word may reuse the slot in the same
      // edge the consumer empties it, so full-rate streams never stall.
      if (done) begin
        if (!oValid || iReady) begin
          oData  <= shift_next;
          oValid <= 1'b1;
`ifdef DESERIALIZADOR_PARIDAD_EN
          oParityError <= paridad_error(shift_next, iSerial);
`endif
        end else begin
          oOverflow <= 1'b1;
        end
      end else if (oValid && iReady) begin
        oValid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_deserializador_sincrono.sv
// ============================================================================
// Module      : tb_deserializador_sincrono
// Description : Self-checking bench for deserializador_sincrono. Expected
//               words go into a scoreboard queue as stimulus is issued; a
//               monitor pops and compares on every delivered word.
// Config      : DESERIALIZADOR_PARIDAD_EN selects the parity-frame sequence.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_deserializador_sincrono;

  logic       clk = 1'b0;
  logic       rst;
  logic       ser;
  logic       val;
  logic       st;
  logic       rdy;
  logic [3:0] data;
  logic       ovalid;
  logic [1:0] idx;
  logic       busy;
  logic       ovf;
  logic       perr;

  int tests = 0;
  int fails = 0;

  // Scoreboard entries: {parity error, data}
  logic [4:0] exp_q[$];

  deserializador_sincrono dut (
    .iClock       (clk),
    .iReset       (rst),
    .iSerial      (ser),
    .iValid       (val),
    .iStart       (st),
    .iReady       (rdy),
    .oData        (data),
    .oValid       (ovalid),
    .oIndex       (idx),
    .oBusy        (busy),
    .oOverflow    (ovf),
    .oParityError (perr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: a word is delivered at the next edge whenever oValid and iReady.
  always @(negedge clk) begin
    if (!rst && ovalid && rdy) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL delivery: got data=%b perr=%b, expected none", data, perr);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        if ({perr, data} !== e) begin
          fails++;
          $display("FAIL delivery: got data=%b perr=%b, expected data=%b perr=%b",
                   data, perr, e[3:0], e[4]);
        end
      end
    end
  end

  task automatic bit_in(input logic s, input logic start);
    ser = s;
    val = 1'b1;
    st  = start;
    @(posedge clk);
    #1;
    val = 1'b0;
    st  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [3:0] w);
    for (int i = 0; i < 4; i++) bit_in(w[i], 1'b0);
`ifdef DESERIALIZADOR_PARIDAD_EN
    bit_in(^w, 1'b0);
`endif
  endtask

  task automatic check_reset(input string tag);
    check({tag, " oValid"}, int'(ovalid), 0);
    check({tag, " oData"}, int'(data), 0);
    check({tag, " oIndex"}, int'(idx), 0);
    check({tag, " oBusy"}, int'(busy), 0);
    check({tag, " oOverflow"}, int'(ovf), 0);
    check({tag, " oParityError"}, int'(perr), 0);
  endtask

  initial begin
    rst = 1'b1; ser = 1'b0; val = 1'b0; st = 1'b0; rdy = 1'b0;
    idle(2);
    check_reset("reset");
    rst = 1'b0;

`ifdef DESERIALIZADOR_PARIDAD_EN
    rdy = 1'b1;
    exp_q.push_back({1'b0, 4'b1101});
    bit_in(1, 0); bit_in(0, 0); bit_in(1, 0); bit_in(1, 0);
    check("par busy before parity bit", int'(busy), 1);
    bit_in(1, 0);
    check("par good oValid", int'(ovalid), 1);
    check("par good oData", int'(data), 4'b1101);
    check("par good oParityError", int'(perr), 0);
    idle(1);
    exp_q.push_back({1'b1, 4'b1101});
    bit_in(1, 0); bit_in(0, 0); bit_in(1, 0); bit_in(1, 0); bit_in(0, 0);
    check("par bad oParityError", int'(perr), 1);
    check("par bad oData", int'(data), 4'b1101);
    idle(1);
    exp_q.push_back({1'b0, 4'b0110});
    send_word(4'b0110);
    check("par word2 oParityError", int'(perr), 0);
    check("par overflow", int'(ovf), 0);
`else
    // Basic word 1101, LSB first
    rdy = 1'b1;
    exp_q.push_back({1'b0, 4'b1101});
    bit_in(1, 0);
    check("t1 oIndex after bit0", int'(idx), 1);
    check("t1 oBusy after bit0", int'(busy), 1);
    bit_in(0, 0); bit_in(1, 0);
    check("t1 oIndex after bit2", int'(idx), 3);
    check("t1 oValid before bit3", int'(ovalid), 0);
    bit_in(1, 0);
    check("t1 oValid", int'(ovalid), 1);
    check("t1 oData", int'(data), 4'b1101);
    check("t1 oIndex wrap", int'(idx), 0);
    check("t1 oBusy end", int'(busy), 0);
    idle(1);
    check("t1 oValid drop", int'(ovalid), 0);
    check("t1 oData held", int'(data), 4'b1101);

    // Restart mid-word: partial 0,1 discarded
    bit_in(0, 0); bit_in(1, 0);
    exp_q.push_back({1'b0, 4'b1001});
    bit_in(1, 1);
    check("t2 oIndex after restart", int'(idx), 1);
    check("t2 oBusy after restart", int'(busy), 1);
    bit_in(0, 0);
    check("t2 oBusy b1", int'(busy), 1);
    bit_in(0, 0);
    check("t2 oBusy b2", int'(busy), 1);
    check("t2 oIndex b2", int'(idx), 3);
    bit_in(1, 0);
    check("t2 oData", int'(data), 4'b1001);
    check("t2 oValid", int'(ovalid), 1);
    idle(1);

    // Overflow: consumer stalled, second word dropped
    rdy = 1'b0;
    exp_q.push_back({1'b0, 4'b0011});
    send_word(4'b0011);
    check("t3 oValid first", int'(ovalid), 1);
    check("t3 no overflow yet", int'(ovf), 0);
    send_word(4'b1111);
    check("t3 oData kept", int'(data), 4'b0011);
    check("t3 oOverflow", int'(ovf), 1);
    check("t3 oValid held", int'(ovalid), 1);
    rdy = 1'b1;
    idle(1);
    check("t3 oValid after accept", int'(ovalid), 0);
    check("t3 oOverflow sticky", int'(ovf), 1);

    // Reset mid-word with an undelivered word held
    rdy = 1'b0;
    send_word(4'b0110);
    bit_in(1, 0); bit_in(1, 0);
    check("t5 oValid held", int'(ovalid), 1);
    check("t5 oIndex mid", int'(idx), 2);
    rst = 1'b1;
    ser = 1'b1; val = 1'b1; st = 1'b1; rdy = 1'b1;
    idle(1);
    check_reset("t5 reset");
    rst = 1'b0; val = 1'b0; st = 1'b0;

    // Back-to-back words at full rate
    exp_q.push_back({1'b0, 4'hA});
    exp_q.push_back({1'b0, 4'h5});
    exp_q.push_back({1'b0, 4'hF});
    send_word(4'hA);
    check("t4 oValid A", int'(ovalid), 1);
    check("t4 oData A", int'(data), 4'hA);
    send_word(4'h5);
    check("t4 oData 5", int'(data), 4'h5);
    send_word(4'hF);
    check("t4 oData F", int'(data), 4'hF);
    check("t4 oOverflow", int'(ovf), 0);
    idle(1);

    // Start without a valid bit returns to idle
    bit_in(1, 0); bit_in(1, 0);
    st = 1'b1;
    idle(1);
    st = 1'b0;
    check("t6 oIndex after bare start", int'(idx), 0);
    check("t6 oBusy after bare start", int'(busy), 0);

    // Gaps between bits are ignored
    exp_q.push_back({1'b0, 4'b0100});
    bit_in(0, 0); idle(3);
    bit_in(0, 0); idle(1);
    bit_in(1, 0); idle(2);
    check("t6 oIndex in gap", int'(idx), 3);
    check("t6 oValid in gap", int'(ovalid), 0);
    bit_in(0, 0);
    check("t6 oData", int'(data), 4'b0100);
    check("t6 oOverflow", int'(ovf), 0);
`endif

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("scoreboard drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
